// File: rtl/featuremap_accum.sv
`default_nettype none
// ============================================================================
// Module      : featuremap_accum
// Description : Sums NUM_CH signed fixed-point channels per pixel through a
//               registered pairwise adder tree, adds a constant bias, applies
//               an activation (none / ReLU / leaky ReLU), saturates to
//               DATA_WIDTH and tags the last pixel of each IMG_SIZE x IMG_SIZE
//               frame. One pixel per cycle, no backpressure.
//               Latency = log2(NUM_CH) + 2 cycles.
// Ports       : Clk       - clock, rising edge
//               Rst       - asynchronous active-low reset
//               data_in   - NUM_CH packed channels, channel k at
//                           [k*DATA_WIDTH +: DATA_WIDTH]
//               valid_in  - data_in valid this cycle
//               sof_in    - first pixel of a frame (qualified by valid_in)
//               data_out  - activated, saturated pixel sum (holds when idle)
//               valid_out - data_out valid this cycle
//               last_out  - final pixel of a frame (with valid_out)
// Revision    : 1.0 - initial release
// ============================================================================
module featuremap_accum #(
  parameter int NUM_CH      = 32,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int BIAS        = 0,
  parameter int ACT_MODE    = 2,
  parameter int LEAKY_SHIFT = 3,
  parameter int IMG_SIZE    = 104
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic                         valid_in,
  input  logic                         sof_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  output logic                         last_out
);

  localparam int STAGES    = $clog2(NUM_CH);
  localparam int LAT       = STAGES + 2;
  localparam int SUM_W     = DATA_WIDTH + STAGES;
  localparam int BIAS_W    = SUM_W + 1;
  localparam int PIX_TOTAL = IMG_SIZE * IMG_SIZE;
  localparam int CNT_W     = (PIX_TOTAL > 1) ? $clog2(PIX_TOTAL) : 1;

  localparam logic [CNT_W-1:0]             CNT_LAST = CNT_W'(PIX_TOTAL - 1);
  localparam logic signed [DATA_WIDTH-1:0] BIAS_VAL = DATA_WIDTH'(BIAS);
  localparam logic [DATA_WIDTH-1:0]        SAT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0]        SAT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Fractional bits are shared by inputs, bias and output, so no rescaling is
  // needed anywhere; the parameter only has to leave room for a sign bit.
  if (NUM_CH < 2 || (NUM_CH & (NUM_CH - 1)) != 0 || FRAC_BITS >= DATA_WIDTH ||
      ACT_MODE < 0 || ACT_MODE > 2) begin : g_param_check
    $error("featuremap_accum: illegal parameter combination");
  end

  // --------------------------------------------------------------------------
  // Pixel counter. sof_in overrides the running count (and therefore also
  // suppresses last on a pixel that would otherwise close the frame).
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] cur_cnt;
  logic             pix_last;

  always_comb begin
    cur_cnt  = sof_in ? '0 : pix_cnt;
    pix_last = (cur_cnt == CNT_LAST) && !sof_in;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pix_cnt <= '0;
    end else if (valid_in) begin
      pix_cnt <= (cur_cnt == CNT_LAST) ? '0 : cur_cnt + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Valid / last side-band, delayed by the full pipeline latency.
  // --------------------------------------------------------------------------
  logic [LAT-1:0] vld_pipe;
  logic [LAT-1:0] last_pipe;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[LAT-2:0], valid_in};
      last_pipe <= {last_pipe[LAT-2:0], valid_in & pix_last};
    end
  end

  assign valid_out = vld_pipe[LAT-1];
  assign last_out  = last_pipe[LAT-1];

  // --------------------------------------------------------------------------
  // Adder tree. Stage s holds NUM_CH>>s partial sums of DATA_WIDTH+s bits;
  // each operand is sign-extended by one bit so no stage can overflow.
  // Stage 0 is just the input bus.
  // --------------------------------------------------------------------------
  for (genvar s = 0; s <= STAGES; s++) begin : g_stage
    localparam int W = DATA_WIDTH + s;
    localparam int N = NUM_CH >> s;
    logic [N*W-1:0] sum;

    if (s == 0) begin : g_in
      assign sum = data_in;
    end else begin : g_add
      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
          sum <= '0;
        end else begin
          for (int k = 0; k < N; k++) begin
            sum[k*W +: W] <=
              {g_stage[s-1].sum[(2*k+1)*(W-1)-1], g_stage[s-1].sum[(2*k)*(W-1) +: W-1]} +
              {g_stage[s-1].sum[(2*k+2)*(W-1)-1], g_stage[s-1].sum[(2*k+1)*(W-1) +: W-1]};
          end
        end
      end
    end
  end

  logic signed [SUM_W-1:0] tree_sum;
  assign tree_sum = g_stage[STAGES].sum;

  // --------------------------------------------------------------------------
  // Bias stage, one extra bit so the addition cannot wrap.
  // --------------------------------------------------------------------------
  logic signed [BIAS_W-1:0] biased;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      biased <= '0;
    end else begin
      biased <= BIAS_W'(tree_sum) + BIAS_W'(BIAS_VAL);
    end
  end

  // --------------------------------------------------------------------------
  // Activation and saturation. The arithmetic shift floors, which gives the
  // round-toward-negative-infinity behaviour wanted for leaky ReLU.
  // --------------------------------------------------------------------------
  logic signed [BIAS_W-1:0]   act;
  logic [BIAS_W-DATA_WIDTH:0] act_hi;
  logic [DATA_WIDTH-1:0]      sat;

  always_comb begin
    act = biased;
    if (biased[BIAS_W-1]) begin
      if (ACT_MODE == 1) begin
        act = '0;
      end else if (ACT_MODE == 2) begin
        act = biased >>> LEAKY_SHIFT;
      end
    end

    // The value fits in DATA_WIDTH only if every bit from the output sign bit
    // upward is a copy of the same sign.
    act_hi = act[BIAS_W-1:DATA_WIDTH-1];
    if (act_hi == '0 || act_hi == '1) begin
      sat = act[DATA_WIDTH-1:0];
    end else if (act[BIAS_W-1]) begin
      sat = SAT_MIN;
    end else begin
      sat = SAT_MAX;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      data_out <= '0;
    end else if (vld_pipe[LAT-2]) begin
      data_out <= sat;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_featuremap_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_featuremap_accum
// Description : Directed self-checking bench for featuremap_accum. Four
//               instances share one stimulus bus: leaky ReLU (main), ReLU,
//               no activation, and no activation with a +0.5 bias. All use a
//               4x4 frame so frame boundaries are reached quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_featuremap_accum;

  localparam int NC = 32;
  localparam int DW = 16;
  localparam int L  = 7;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic [NC*DW-1:0] data_in  = '0;
  logic             valid_in = 1'b0;
  logic             sof_in   = 1'b0;

  logic [DW-1:0] d2, d1, d0, db;
  logic          v2, v1, v0, vb;
  logic          l2, l1, l0, lb;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  featuremap_accum #(.NUM_CH(NC), .DATA_WIDTH(DW), .FRAC_BITS(8), .BIAS(0),
                     .ACT_MODE(2), .LEAKY_SHIFT(3), .IMG_SIZE(4)) dut (
    .Clk(clk), .Rst(rst_n), .data_in(data_in), .valid_in(valid_in), .sof_in(sof_in),
    .data_out(d2), .valid_out(v2), .last_out(l2));

  featuremap_accum #(.NUM_CH(NC), .DATA_WIDTH(DW), .FRAC_BITS(8), .BIAS(0),
                     .ACT_MODE(1), .LEAKY_SHIFT(3), .IMG_SIZE(4)) dut_relu (
    .Clk(clk), .Rst(rst_n), .data_in(data_in), .valid_in(valid_in), .sof_in(sof_in),
    .data_out(d1), .valid_out(v1), .last_out(l1));

  featuremap_accum #(.NUM_CH(NC), .DATA_WIDTH(DW), .FRAC_BITS(8), .BIAS(0),
                     .ACT_MODE(0), .LEAKY_SHIFT(3), .IMG_SIZE(4)) dut_none (
    .Clk(clk), .Rst(rst_n), .data_in(data_in), .valid_in(valid_in), .sof_in(sof_in),
    .data_out(d0), .valid_out(v0), .last_out(l0));

  featuremap_accum #(.NUM_CH(NC), .DATA_WIDTH(DW), .FRAC_BITS(8), .BIAS(128),
                     .ACT_MODE(0), .LEAKY_SHIFT(3), .IMG_SIZE(4)) dut_bias (
    .Clk(clk), .Rst(rst_n), .data_in(data_in), .valid_in(valid_in), .sof_in(sof_in),
    .data_out(db), .valid_out(vb), .last_out(lb));

  // Output capture, 1 ns after the active edge, keyed on the main instance.
  typedef struct {
    logic [DW-1:0] d2, d1, d0, db;
    logic          v1, v0, vb;
    logic          l2, l1, l0, lb;
  } out_t;
  out_t q[$];

  always @(posedge clk) begin
    #1;
    if (v2 === 1'b1) q.push_back('{d2, d1, d0, db, v1, v0, vb, l2, l1, l0, lb});
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1);
  end

  function automatic logic [NC*DW-1:0] fill(input logic [DW-1:0] v);
    logic [NC*DW-1:0] r;
    for (int k = 0; k < NC; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [NC*DW-1:0] pix(input int i);
    logic [NC*DW-1:0] r;
    r = '0;
    r[DW-1:0] = DW'(i * 256);
    return r;
  endfunction

  // All drive tasks start and end just after a falling edge.
  task automatic drive_pixel(input logic [NC*DW-1:0] d, input logic sof);
    data_in  = d;
    valid_in = 1'b1;
    sof_in   = sof;
    @(negedge clk);
    valid_in = 1'b0;
    sof_in   = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    sof_in   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_outputs(input int n, input string name);
    int cyc = 0;
    while (q.size() < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (q.size() < n) begin
      fails++;
      $display("FAIL %s_count: got %0d outputs, expected %0d", name, q.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({v2, v1, v0, vb, l2, l1, l0, lb} !== 8'h00) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 00000000", {v2, v1, v0, vb, l2, l1, l0, lb});
    end
    checks++;
    if ({d2, d1, d0, db} !== 64'h0) begin
      fails++;
      $display("FAIL reset_data: got %h expected 0", {d2, d1, d0, db});
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  // One pixel of all 1.0 -> 32.0 exactly L cycles later, then held.
  task automatic test_unity_sum();
    q.delete();
    drive_pixel(fill(16'h0100), 1'b0);
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (v2 !== (k == L)) begin
        fails++;
        $display("FAIL unity_valid_c%0d: got %b expected %b", k, v2, (k == L));
      end
      if (k >= L) begin
        checks++;
        if (d2 !== 16'h2000) begin
          fails++;
          $display("FAIL unity_data_c%0d: got %h expected 2000", k, d2);
        end
      end
      if (k == L) begin
        checks++;
        if ({d1, d0, db} !== {16'h2000, 16'h2000, 16'h2080} || l2 !== 1'b0) begin
          fails++;
          $display("FAIL unity_others: got %h %h %h last %b expected 2000 2000 2080 last 0",
                   d1, d0, db, l2);
        end
      end
      @(negedge clk);
    end
  endtask

  // Activation, rounding and saturation, pixels streamed back to back.
  task automatic test_activation();
    logic [NC*DW-1:0] vec [6];
    logic [DW-1:0] e2 [6] = '{16'hFF00, 16'hFF00, 16'h7FFF, 16'h8000, 16'h1F00, 16'hFFC0};
    logic [DW-1:0] e1 [6] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h1F00, 16'h0000};
    logic [DW-1:0] e0 [6] = '{16'hF800, 16'hF801, 16'h7FFF, 16'h8000, 16'h1F00, 16'hFE00};
    logic [DW-1:0] eb [6] = '{16'hF880, 16'hF881, 16'h7FFF, 16'h8000, 16'h1F80, 16'hFE80};
    vec[0] = '0;
    vec[0][DW-1:0] = 16'hF800;
    vec[1] = '0;
    vec[1][DW-1:0] = 16'hF801;
    vec[2] = fill(16'h7FFF);
    vec[3] = fill(16'h8000);
    for (int k = 0; k < NC; k++) vec[4][k*DW +: DW] = DW'(k * 16);
    vec[5] = fill(16'hFFF0);
    q.delete();
    for (int i = 0; i < 6; i++) drive_pixel(vec[i], 1'b0);
    wait_outputs(6, "act");
    for (int i = 0; i < 6 && i < q.size(); i++) begin
      checks++;
      if ({q[i].d2, q[i].d1, q[i].d0, q[i].db} !== {e2[i], e1[i], e0[i], eb[i]}) begin
        fails++;
        $display("FAIL act_vec%0d: got %h %h %h %h expected %h %h %h %h", i,
                 q[i].d2, q[i].d1, q[i].d0, q[i].db, e2[i], e1[i], e0[i], eb[i]);
      end
      checks++;
      if ({q[i].v1, q[i].v0, q[i].vb} !== 3'b111) begin
        fails++;
        $display("FAIL act_valid%0d: got %b expected 111", i, {q[i].v1, q[i].v0, q[i].vb});
      end
    end
    idle(2);
  endtask

  // Two full 4x4 frames back to back, sof only on the first pixel.
  task automatic test_frame_last();
    logic exp_last;
    q.delete();
    for (int i = 0; i < 32; i++) drive_pixel(pix(i), i == 0);
    wait_outputs(32, "frame");
    for (int i = 0; i < 32 && i < q.size(); i++) begin
      exp_last = (i == 15) || (i == 31);
      checks++;
      if ({q[i].l2, q[i].l1, q[i].l0, q[i].lb} !== {4{exp_last}}) begin
        fails++;
        $display("FAIL frame_last%0d: got %b expected %b", i,
                 {q[i].l2, q[i].l1, q[i].l0, q[i].lb}, {4{exp_last}});
      end
      checks++;
      if (q[i].d2 !== DW'(i * 256)) begin
        fails++;
        $display("FAIL frame_data%0d: got %h expected %h", i, q[i].d2, DW'(i * 256));
      end
    end
    idle(2);
  endtask

  // Mid-frame sof at pixel 5, an ignored sof without valid after pixel 7,
  // and sof colliding with the last pixel of a frame (pixel 36).
  task automatic test_sof_resync();
    logic exp_last;
    q.delete();
    for (int i = 0; i < 52; i++) begin
      drive_pixel(pix(i), (i == 0) || (i == 5) || (i == 36));
      if (i == 7) begin
        sof_in = 1'b1;
        @(negedge clk);
        sof_in = 1'b0;
      end
    end
    wait_outputs(52, "sof");
    for (int i = 0; i < 52 && i < q.size(); i++) begin
      exp_last = (i == 20) || (i == 51);
      checks++;
      if (q[i].l2 !== exp_last) begin
        fails++;
        $display("FAIL sof_last%0d: got %b expected %b", i, q[i].l2, exp_last);
      end
    end
    idle(2);
  endtask

  // Reset mid-cycle with three pixels in flight.
  task automatic test_reset_inflight();
    logic exp_last;
    q.delete();
    for (int i = 0; i < 3; i++) drive_pixel(fill(16'h0100), i == 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({d2, d0, db} !== 48'h0 || {v2, l2} !== 2'b00) begin
      fails++;
      $display("FAIL rst_async: got %h %h %h v%b l%b expected 0", d2, d0, db, v2, l2);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({d2, d1, d0, db} !== 64'h0 || {v2, v1, v0, vb, l2, l1, l0, lb} !== 8'h00) begin
      fails++;
      $display("FAIL rst_hold: got %h flags %b expected 0", {d2, d1, d0, db},
               {v2, v1, v0, vb, l2, l1, l0, lb});
    end
    rst_n = 1'b1;
    idle(L + 5);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL rst_flush: got %0d outputs expected 0", q.size());
    end
    q.delete();
    for (int i = 0; i < 16; i++) drive_pixel(pix(i + 1), 1'b0);
    wait_outputs(16, "rst_after");
    for (int i = 0; i < 16 && i < q.size(); i++) begin
      exp_last = (i == 15);
      checks++;
      if (q[i].l2 !== exp_last) begin
        fails++;
        $display("FAIL rst_after_last%0d: got %b expected %b", i, q[i].l2, exp_last);
      end
    end
    idle(2);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_unity_sum();
    test_activation();
    test_frame_last();
    test_sof_resync();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/featuremap_accum.md
FEATUREMAP_ACCUM -- requirements
Module: featuremap_accum

Interface
REQ-001 The block SHALL have the parameter NUM_CH, default 32, meaning the number of input channels summed per output pixel (power of two, 2..64).
REQ-002 The block SHALL have the parameter DATA_WIDTH, default 16, meaning the width of each signed fixed-point channel word and of the output word.
REQ-003 The block SHALL have the parameter FRAC_BITS, default 8, meaning the number of fractional bits shared by inputs, bias and output.
REQ-004 The block SHALL have the parameter BIAS, default 0, meaning a signed DATA_WIDTH bias added once per pixel.
REQ-005 The block SHALL have the parameter ACT_MODE, default 2, meaning the activation: 0 none, 1 ReLU, 2 leaky ReLU.
REQ-006 The block SHALL have the parameter LEAKY_SHIFT, default 3, meaning the arithmetic right shift applied to negative values in leaky mode.
REQ-007 The block SHALL have the parameter IMG_SIZE, default 104, meaning the frame width and height in pixels.
REQ-008 The block SHALL have the port Clk, input, 1 bit: the single clock, rising edge.
REQ-009 The block SHALL have the port Rst, input, 1 bit: asynchronous, active-low reset.
REQ-010 The block SHALL have the port data_in, input, NUM_CH*DATA_WIDTH bits: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 The block SHALL have the port valid_in, input, 1 bit: data_in is valid this cycle.
REQ-012 The block SHALL have the port sof_in, input, 1 bit: qualified by valid_in; marks the first pixel of a frame.
REQ-013 The block SHALL have the port data_out, output, DATA_WIDTH bits: the activated, saturated pixel sum.
REQ-014 The block SHALL have the port valid_out, output, 1 bit: data_out is valid this cycle.
REQ-015 The block SHALL have the port last_out, output, 1 bit: high with valid_out on the final pixel of a frame.

Function
REQ-016 The block SHALL be a fully pipelined design accepting one pixel per cycle, with no backpressure and no bubbles required between valid inputs.
REQ-017 The adder tree SHALL have log2(NUM_CH) registered stages, each pairwise-adding the previous stage's results, with width growing by 1 bit per stage; internal sums SHALL never overflow.
REQ-018 The stage after the tree SHALL add BIAS, sign-extended, in full internal width plus 1 bit.
REQ-019 The final stage SHALL apply the activation as follows: mode 0 passes the value through; mode 1 maps negative values to 0; mode 2 maps negative values to (value >>> LEAKY_SHIFT) and rounds toward negative infinity.
REQ-020 The final stage SHALL then saturate the result to signed DATA_WIDTH, giving 0x7FFF max and 0x8000 min for 16 bits, and register it to data_out.
REQ-021 Total latency from valid_in to valid_out SHALL be L = log2(NUM_CH) + 2 cycles (7 at default).
REQ-022 valid_out SHALL equal valid_in delayed by exactly L cycles.
REQ-023 data_out SHALL hold its last value while valid_out is low.
REQ-024 A pixel counter SHALL count accepted pixels from 0 to IMG_SIZE*IMG_SIZE-1 and wrap to 0.
REQ-025 last_out for a pixel SHALL be asserted when that pixel's count is IMG_SIZE*IMG_SIZE-1; last_out SHALL be delayed alongside valid_out.
REQ-026 A valid_in with sof_in SHALL force that pixel's count to 0, resynchronising mid-frame; the counter SHALL then continue from 1.
REQ-027 sof_in without valid_in SHALL be ignored.
REQ-028 If sof_in arrives on the pixel at count IMG_SIZE*IMG_SIZE-1, sof_in SHALL win: count is 0 and last_out is not asserted for that pixel.

Reset
REQ-029 While Rst is low, valid_out, last_out, data_out, all pipeline valid bits, all pipeline data registers and the pixel counter SHALL be 0.
REQ-030 Reset assertion SHALL take effect immediately and asynchronously; in-flight pixels SHALL be discarded, with no valid_out for them after release.
REQ-031 After Rst rises, the first valid_in SHALL be treated as pixel count 0.

Verification
REQ-032 Default parameters, all 32 channels = 0x0100 (1.0), valid_in for one cycle -> 7 cycles later valid_out=1 and data_out=0x2000 (32.0), then valid_out=0.
REQ-033 ACT_MODE=2, channel 0 = 0xF800 (-8.0), others 0 -> data_out=0xFF00 (-1.0); with ACT_MODE=1 -> 0x0000; with ACT_MODE=0 -> 0xF800.
REQ-034 All channels = 0x7FFF -> data_out=0x7FFF; all channels = 0x8000 with ACT_MODE=0 -> data_out=0x8000.
REQ-035 IMG_SIZE=4, 16 back-to-back valid pixels starting with sof_in -> last_out is high only on the 16th valid_out; a 17th pixel has count 0.
REQ-036 sof_in injected on pixel 5 of a frame, then 15 more pixels -> last_out is high on the 15th pixel after the injected sof_in.
REQ-037 Rst pulsed low while 3 pixels are in flight -> no valid_out for them, all outputs read 0 during reset, and the next pixel after release takes count 0.
